shift_chain_loader: RTL and testbench

Serializing driver for the configuration shift chain. Accepts configuration words over a valid/ready stream, emits one bit per cycle on the chain's serial input with the chain's shift enable asserted, and pulses `done` once exactly `CHAIN_LENGTH` bits have been shifted. It sits between the configuration host interface and the head of a `CHAIN_LENGTH`-bit chain. Optionally, it captures the chain's serial output to return the previous chain contents.

---
 rtl/shift_chain_loader.sv | 157 +++++++++++++++
 tb/tb_shift_chain_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_loader.sv
// shift_chain_loader: serializes configuration words into a CHAIN_LENGTH-bit
// shift chain, LSB of each word first, and pulses done after exactly
// CHAIN_LENGTH shifted bits.
//
// Optional feature macro: SHIFT_CHAIN_LOADER_READBACK_EN
//   defined   : chain_shift_out is captured into readback words (rb_data/rb_valid)
//   undefined : rb_data/rb_valid are tied to 0 and chain_shift_out is ignored
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a load sequence (honoured only when idle)
//   busy, done          sequence in progress / one-cycle completion pulse
//   in_data/valid/ready configuration word stream
//   chain_shift_enable  chain shift enable
//   chain_shift_in      serial data into the chain head
//   chain_shift_out     serial data from the chain tail (readback only)
//   rb_data, rb_valid   readback word and its one-cycle qualifier
module shift_chain_loader #(
    parameter int unsigned CHAIN_LENGTH = 64,
    parameter int unsigned WORD_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  chain_shift_enable,
    output logic                  chain_shift_in,
    input  logic                  chain_shift_out,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid
);

    localparam int unsigned TCNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned WCNT_W = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WORD_WIDTH-1:0] sreg;
    logic [TCNT_W-1:0]     tcnt;
    logic [WCNT_W-1:0]     wcnt;
    logic                  last_bit;
    logic                  word_end;

    // Bit currently on the chain input is the final chain bit / final word bit.
    assign last_bit = (tcnt == TCNT_W'(CHAIN_LENGTH - 1));
    assign word_end = (wcnt == WCNT_W'(WORD_WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the total-bit limit wins over the word boundary
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  if (in_valid) state_next = S_SHIFT;
            S_SHIFT: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end else if (word_end) begin
                    state_next = S_LOAD;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Shift register and bit counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            tcnt <= '0;
            wcnt <= '0;
        end else begin
            case (state)
                S_IDLE: tcnt <= '0;
                S_LOAD: begin
                    if (in_valid) begin
                        sreg <= in_data;
                        wcnt <= '0;
                    end
                end
                S_SHIFT: begin
                    sreg <= sreg >> 1;
                    tcnt <= tcnt + 1'b1;
                    wcnt <= wcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure decodes of flopped state/data
    assign busy               = (state != S_IDLE);
    assign done               = (state == S_DONE);
    assign in_ready           = (state == S_LOAD);
    assign chain_shift_enable = (state == S_SHIFT);
    assign chain_shift_in     = (state == S_SHIFT) & sreg[0];

`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
    logic [WORD_WIDTH-1:0] rb_shift;
    logic [WORD_WIDTH-1:0] rb_merged;
    logic [WORD_WIDTH-1:0] rb_data_q;
    logic                  rb_valid_q;

    // Old chain bit lands at the same word position as the new bit going in
    assign rb_merged = rb_shift | (WORD_WIDTH'(chain_shift_out) << wcnt);

    // Readback capture; cleared per word so a short last word is zero-padded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_shift   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if ((state == S_LOAD) && in_valid) begin
                rb_shift <= '0;
            end else if (state == S_SHIFT) begin
                rb_shift <= rb_merged;
                if (last_bit || word_end) begin
                    rb_data_q  <= rb_merged;
                    rb_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_chain_shift_out;

    assign unused_chain_shift_out = chain_shift_out;
    assign rb_data                = '0;
    assign rb_valid               = 1'b0;
`endif

endmodule

// File: tb/tb_shift_chain_loader.sv
// Directed bench for shift_chain_loader with a 10-bit chain and 4-bit words.
module tb_shift_chain_loader;

    localparam int unsigned CL = 10;
    localparam int unsigned WW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          chain_shift_enable;
    logic          chain_shift_in;
    logic          chain_shift_out;
    logic [WW-1:0] rb_data;
    logic          rb_valid;

    // Attached chain: first bit shifted ends in the MSB
    logic [CL-1:0] chain = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int en_cnt;
    int done_cnt;
    int done_cyc;
    int en_while_ready;
    logic [WW-1:0] rb_q[$];

    shift_chain_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .chain_shift_enable (chain_shift_enable),
        .chain_shift_in     (chain_shift_in),
        .chain_shift_out    (chain_shift_out),
        .rb_data            (rb_data),
        .rb_valid           (rb_valid)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (chain_shift_enable) chain <= {chain[CL-2:0], chain_shift_in};
    end
    assign chain_shift_out = chain[CL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and record the outputs of the new cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (chain_shift_enable) en_cnt++;
        if (in_ready && chain_shift_enable) en_while_ready++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rb_valid) rb_q.push_back(rb_data);
    endtask

    task automatic clear_stats();
        cyc = 0;
        en_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        en_while_ready = 0;
        rb_q.delete();
    endtask

    // Full load sequence; stall = LOAD cycles with in_valid low before each word
    task automatic run_seq(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input logic [WW-1:0] w2, input int stall, input int start_at,
                           input logic [CL-1:0] exp_chain, input int exp_done_cyc,
                           input bit chk_rb, input logic [WW-1:0] r0, input logic [WW-1:0] r1,
                           input logic [WW-1:0] r2);
        logic [WW-1:0] words[3];
        int widx;
        int wait_cnt;
        bit acc;
        words = '{w0, w1, w2};
        widx = 0;
        wait_cnt = 0;
        clear_stats();
        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
        for (int i = 0; i < 80; i++) begin
            acc = 1'b0;
            if (in_ready && wait_cnt >= stall) begin
                in_valid = 1'b1;
                in_data = (widx < 3) ? words[widx] : 4'h0;
                acc = 1'b1;
            end else if (in_ready) begin
                in_valid = 1'b0;
                wait_cnt++;
            end else begin
                // Garbage offered outside LOAD must be ignored
                in_valid = 1'b1;
                in_data = 4'hF;
            end
            start = (i == start_at);
            step();
            start = 1'b0;
            if (acc) begin
                widx++;
                wait_cnt = 0;
            end
            if (done_cnt > 0) break;
        end
        repeat (3) step();
        in_valid = 1'b0;
        chk({tag, "_chain"}, 32'(chain), 32'(exp_chain));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
        chk({tag, "_en_cnt"}, 32'(en_cnt), 32'(CL));
        chk({tag, "_en_in_load"}, 32'(en_while_ready), 32'd0);
        chk({tag, "_words"}, 32'(widx), 32'd3);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
        if (chk_rb) begin
            chk({tag, "_rb_n"}, 32'(rb_q.size()), 32'd3);
            if (rb_q.size() == 3) begin
                chk({tag, "_rb0"}, 32'(rb_q[0]), 32'(r0));
                chk({tag, "_rb1"}, 32'(rb_q[1]), 32'(r1));
                chk({tag, "_rb2"}, 32'(rb_q[2]), 32'(r2));
            end
        end
`else
        chk({tag, "_rb_n"}, 32'(rb_q.size()), 32'd0);
        chk({tag, "_rb_data"}, 32'(rb_data), 32'd0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_shift_en"}, 32'(chain_shift_enable), 32'd0);
        chk({tag, "_shift_in"}, 32'(chain_shift_in), 32'd0);
        chk({tag, "_rb_data"}, 32'(rb_data), 32'd0);
        chk({tag, "_rb_valid"}, 32'(rb_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle: valid without start does nothing
        clear_stats();
        in_valid = 1'b1;
        in_data = 4'h5;
        repeat (4) step();
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_en_cnt", 32'(en_cnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done_cnt", 32'(done_cnt), 32'd0);
        in_valid = 1'b0;

        // Back-to-back load; chain started at zero so readback is all zero
        run_seq("seq", 4'h5, 4'hA, 4'h3, 0, -1, 10'h297, 14, 1'b1, 4'h0, 4'h0, 4'h0);
        // Three stall cycles in every LOAD add nine cycles
        run_seq("stall", 4'h5, 4'hA, 4'h3, 3, -1, 10'h297, 23, 1'b1, 4'h5, 4'hA, 4'h3);
        // Start pulsed during the first word's SHIFT is ignored
        run_seq("start_mid", 4'h5, 4'hA, 4'h3, 0, 2, 10'h297, 14, 1'b1, 4'h5, 4'hA, 4'h3);

        // Reset during the second word's SHIFT
        clear_stats();
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 4'hA;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("abort_pre_en", 32'(chain_shift_enable), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        repeat (15) step();
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_en_cnt", 32'(en_cnt), 32'd0);
        in_valid = 1'b0;

        // Clean sequence after the abort; readback holds leftover data, unchecked
        run_seq("after_abort", 4'h5, 4'hA, 4'h3, 0, -1, 10'h297, 14, 1'b0, 4'h0, 4'h0, 4'h0);
        // Zero load returns the previous 0x297 contents as 5, A, 3
        run_seq("zero", 4'h0, 4'h0, 4'h0, 0, -1, 10'h000, 14, 1'b1, 4'h5, 4'hA, 4'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
